// File: rtl/debounce_pkg.sv
// Shared state codes for the pushbutton debouncer; used by the RTL debug
// decode and by anything that interprets the state port.
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  // The debounced level is high while a press is accepted and not yet released.
  function automatic logic is_held(input state_t st);
    return (st == PRESSED) || (st == RELEASE_WAIT);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; both stages clear on reset.
module sync_2ff (
  input  logic clock,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic sync1_reg;
  logic sync2_reg;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
    end else begin
      sync1_reg <= d;
      sync2_reg <= sync1_reg;
    end
  end

  assign q = sync2_reg;

endmodule

// File: rtl/debounce_pulse.sv
// Pushbutton conditioner: synchronise, debounce with a stable-count timer, and
// emit one w pulse per press. Define HOLD_REPEAT_EN for auto-repeat while held.
module debounce_pulse
  import debounce_pkg::*;
#(
  parameter int STABLE_CNT    = 16,
  parameter int CNT_W         = 20,
  parameter int ACTIVE_LOW    = 1,
  parameter int REPEAT_CYCLES = 32
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       btn_raw,
  output logic       w,
  output logic       btn_level,
  output logic [1:0] state
);

  localparam int TIMER_MAX = (STABLE_CNT > REPEAT_CYCLES) ? STABLE_CNT : REPEAT_CYCLES;
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CNT - 1);

  generate
    if (STABLE_CNT < 2 || longint'(TIMER_MAX) >= (longint'(1) << CNT_W)) begin : g_param_check
      $error("debounce_pulse: STABLE_CNT must be >= 2 and CNT_W wide enough for the timer");
    end
  endgenerate

  logic   p;
  logic   s;
  state_t state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic   w_reg;
  logic   level_reg;

  assign p = btn_raw ^ (ACTIVE_LOW != 0);

  sync_2ff u_sync (
    .clock (clock),
    .rst   (rst),
    .d     (p),
    .q     (s)
  );

`ifdef HOLD_REPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
`endif

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      w_reg     <= 1'b0;
      level_reg <= 1'b0;
    end else begin
      w_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (s) begin
            state_reg <= PRESS_WAIT;
            cnt_reg   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!s) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
          end else if (cnt_reg == STABLE_LAST) begin
            state_reg <= PRESSED;
            cnt_reg   <= '0;
            w_reg     <= 1'b1;
            level_reg <= is_held(PRESSED);
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        PRESSED: begin
          if (!s) begin
            state_reg <= RELEASE_WAIT;
            cnt_reg   <= '0;
          end else begin
`ifdef HOLD_REPEAT_EN
            // Held button: re-fire every REPEAT_CYCLES edges after the accepting pulse.
            if (cnt_reg == REPEAT_LAST) begin
              cnt_reg <= '0;
              w_reg   <= 1'b1;
            end else begin
              cnt_reg <= cnt_reg + CNT_W'(1);
            end
`else
            cnt_reg <= '0;
`endif
          end
        end
        RELEASE_WAIT: begin
          // A bounce back to pressed resumes the held state without a new pulse.
          if (s) begin
            state_reg <= PRESSED;
            cnt_reg   <= '0;
          end else if (cnt_reg == STABLE_LAST) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            level_reg <= is_held(IDLE);
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        default: begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
          level_reg <= 1'b0;
        end
      endcase
    end
  end

  assign w         = w_reg;
  assign btn_level = level_reg;
  assign state     = state_reg;

endmodule

// File: doc/debounce_pulse.md
Name: debounce_pulse

Overview:
- Input conditioner directly upstream of the w-counting Moore/Mealy FSM.
- Takes a raw, bouncy, asynchronous pushbutton (board KEY) and synchronises it into the clock domain.
- Debounces it with a stable-count timer.
- Emits exactly one single-cycle w pulse per clean press, so the downstream counter advances once per press.

Parameters:
- STABLE_CNT, 16, consecutive cycles the synchronised input must hold before a press or release is accepted; must be >= 2. Board builds override it to about 500000.
- CNT_W, 20, width of the internal timer; must satisfy 2^CNT_W > max(STABLE_CNT, REPEAT_CYCLES).
- ACTIVE_LOW, 1, 1 means btn_raw is asserted when 0 (board KEY); 0 means asserted when 1.
- REPEAT_CYCLES, 32, auto-repeat period; used only with HOLD_REPEAT_EN.

Ports:
- clock, input, 1, system clock; all state updates on the rising edge.
- rst, input, 1, asynchronous active-high reset.
- btn_raw, input, 1, raw pushbutton; asynchronous, may bounce.
- w, output, 1, registered one-cycle press pulse feeding the counter FSM.
- btn_level, output, 1, registered debounced level; 1 while the press is accepted.
- state, output, 2, current FSM state, for debug and LEDs.

Behaviour:
- Polarity: p = btn_raw XOR ACTIVE_LOW, so p=1 means pressed.
- Synchroniser: p passes through two flops, sync1 then sync2; s = sync2. Both flops reset to 0.
- Reset (async, rst=1): state=IDLE, cnt=0, w=0, btn_level=0, sync flops 0. Applying reset mid-press or mid-debounce aborts with no pulse. Release of reset takes effect at the next edge.
- State encodings: IDLE=0, PRESS_WAIT=1, PRESSED=2, RELEASE_WAIT=3. All transitions are evaluated at the rising edge.
- IDLE:
  - s=1: go to PRESS_WAIT, cnt<=0.
  - s=0: stay.
- PRESS_WAIT:
  - s=0 (bounce): go to IDLE, no pulse.
  - s=1 and cnt==STABLE_CNT-1: go to PRESSED, w<=1, cnt<=0.
  - otherwise: cnt<=cnt+1.
- PRESSED:
  - s=0: go to RELEASE_WAIT, cnt<=0.
  - s=1: stay.
- RELEASE_WAIT:
  - s=1 (bounce): go to PRESSED, cnt<=0, no pulse.
  - s=0 and cnt==STABLE_CNT-1: go to IDLE.
  - otherwise: cnt<=cnt+1.
- Outputs:
  - w=0 on every edge except those named above; it is never high for two consecutive cycles, except as defined under the optional feature.
  - btn_level=1 exactly when state is PRESSED or RELEASE_WAIT.
- Latency: with p stable at 1 from edge 0, w is high between edges STABLE_CNT+2 and STABLE_CNT+3; for STABLE_CNT=16 that is edges 18 to 19.
- Timer arithmetic: cnt is unsigned CNT_W bits and never wraps, because it is cleared before it can exceed STABLE_CNT-1.
- Illegal states: none are possible with a 2-bit encoding; the default branch goes to IDLE.

Optional Feature:
- Macro: HOLD_REPEAT_EN.
- Defined (auto-repeat):
  - In PRESSED with s=1, cnt increments each edge.
  - When cnt==REPEAT_CYCLES-1, w<=1 and cnt<=0.
  - The first repeat pulse arrives REPEAT_CYCLES edges after the initial pulse, then one pulse every REPEAT_CYCLES edges.
  - Re-entry to PRESSED from RELEASE_WAIT clears cnt and emits no pulse.
- Undefined: cnt is held at 0 in PRESSED, and only one pulse is produced per press.

Decomposition:
- Shared package debounce_pkg: the four 2-bit state codes (IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT), so the debug decode and the testbench share one definition.
- Sub-module sync_2ff: 1-bit two-flop synchroniser with async active-high reset to 0, reusable for other board inputs.
- The FSM and timer stay in debounce_pulse.

Test Plan:
- Clean press (STABLE_CNT=16, ACTIVE_LOW=1): btn_raw goes 1 to 0 at edge 0 and is held -> w=1 for exactly one cycle between edges 18 and 19; btn_level=1 from edge 18; state sequence 0,1,2.
- Bouncy press: btn_raw toggles every 3 cycles for 30 cycles, then holds low -> no w during bouncing; exactly one w pulse 18 edges after the last transition to low.
- Release bounce: while pressed, btn_raw goes high for 5 cycles then low again -> state 2 to 3 to 2; no pulse; btn_level stays 1; a later clean release returns to IDLE after 16 stable cycles plus 2 synchroniser edges.
- Reset mid-debounce: assert rst while state=1 and cnt=10 -> state=0, w=0, btn_level=0 immediately (asynchronous); no pulse after release even though btn_raw is still low, until a full STABLE_CNT window completes.
- Downstream integration: five clean presses into the counter FSM -> countMoore asserts after the 4th w pulse and the state wraps to 0 after the 5th.
- HOLD_REPEAT_EN, REPEAT_CYCLES=32: hold for 100 cycles past acceptance -> pulses at edges 18, 50 and 82, then none after release.
